motor_drive_supervisor: RTL and testbench

MOTOR_DRIVE_SUPERVISOR -- requirements
Module: motor_drive_supervisor

---
 rtl/motor_drive_supervisor_pkg.sv | 18 +
 rtl/motor_drive_supervisor_if.sv | 27 ++
 rtl/motor_drive_supervisor_pwm.sv | 32 +++
 rtl/motor_drive_supervisor.sv | 127 ++++++++++++
 tb/tb_motor_drive_supervisor.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/motor_drive_supervisor_pkg.sv
// Shared types and default parameter values for the motor drive supervisor.
// Used by the interface, the PWM generator and the top level.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RUN        = 2'd1,
        ST_BRAKE      = 2'd2,
        ST_TILT_FAULT = 2'd3
    } state_t;

    localparam int DEF_WIDTH       = 12;
    localparam int DEF_TILT_LIMIT  = 512;
    localparam int DEF_RAMP_STEP   = 16;
    localparam int DEF_RAMP_DIV    = 4;
    localparam int DEF_HOLD_CYCLES = 1000;

endpackage

// File: rtl/motor_drive_supervisor_if.sv
// Rider/sensor inputs and drive outputs of the supervisor, bundled as one port.
// master = the side producing the rider/sensor inputs; slave = the supervisor.
interface motor_drive_supervisor_if #(
    parameter int WIDTH = motor_pkg::DEF_WIDTH
);
    logic                    enable;
    logic                    mode_sel;
    logic [WIDTH-1:0]        assist_req;
    logic [WIDTH-1:0]        throttle;
    logic signed [WIDTH-1:0] roll;
    logic signed [WIDTH-1:0] pitch;
    logic                    brake;
    logic                    pwm_out;
    logic [WIDTH-1:0]        duty;
    logic [1:0]              state;
    logic                    fault_tilt;

    modport master (
        output enable, mode_sel, assist_req, throttle, roll, pitch, brake,
        input  pwm_out, duty, state, fault_tilt
    );

    modport slave (
        input  enable, mode_sel, assist_req, throttle, roll, pitch, brake,
        output pwm_out, duty, state, fault_tilt
    );
endinterface

// File: rtl/motor_drive_supervisor_pwm.sv
// Free-running PWM generator; compare value is double-buffered and only
// reloads at counter wrap, unless force_zero cuts it immediately.
module motor_pwm_gen #(
    parameter int WIDTH = motor_pkg::DEF_WIDTH
) (
    input  logic             c50m,
    input  logic             reset,
    input  logic [WIDTH-1:0] duty,
    input  logic             force_zero,
    output logic             pwm_out
);
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_cmp;
    logic             r_pwm;

    always_ff @(posedge c50m or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_cmp <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (force_zero)
                r_cmp <= '0;
            else if (r_cnt == '1)
                r_cmp <= duty;
            r_pwm <= (r_cnt < r_cmp);
        end
    end

    assign pwm_out = r_pwm;
endmodule

// File: rtl/motor_drive_supervisor.sv
// Motor drive supervisor: target select, duty ramp, state machine and PWM.
// Tilt cutoff is compiled in only when MOTOR_TILT_CUTOFF_EN is defined.
module motor_drive_supervisor
    import motor_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TILT_LIMIT  = DEF_TILT_LIMIT,
    parameter int RAMP_STEP   = DEF_RAMP_STEP,
    parameter int RAMP_DIV    = DEF_RAMP_DIV,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                     c50m,
    input  logic                     reset,
    motor_drive_supervisor_if.slave  bus
);
    localparam int               TW     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int               HW     = $clog2(HOLD_CYCLES + 1);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(RAMP_STEP);

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_duty, w_duty_next;
    logic [TW-1:0]    r_tick, w_tick_next;
    logic [HW-1:0]    r_hold, w_hold_next;
    logic [WIDTH-1:0] w_gap, w_step;
    logic             w_tilt, w_hold_ok, w_force_zero;

`ifdef MOTOR_TILT_CUTOFF_EN
    // Magnitude of a two's-complement word; the most negative value clamps.
    function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH-1:0] v);
        if (!v[WIDTH-1])
            return v;
        if (v == {1'b1, {(WIDTH-1){1'b0}}})
            return {1'b0, {(WIDTH-1){1'b1}}};
        return -v;
    endfunction

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(TILT_LIMIT);

    assign w_tilt         = (sat_abs(bus.roll) > LIMIT_W) || (sat_abs(bus.pitch) > LIMIT_W);
    assign bus.fault_tilt = (r_state == ST_TILT_FAULT);
`else
    logic w_unused_tilt;
    assign w_unused_tilt  = ^{bus.roll, bus.pitch};
    assign w_tilt         = 1'b0;
    assign bus.fault_tilt = 1'b0;
`endif

    assign w_hold_ok    = !w_tilt && (r_target == '0);
    assign w_force_zero = (r_state == ST_RUN) && (w_state_next != ST_RUN);

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = '0;
        case (r_state)
            ST_IDLE:
                if (bus.enable && !bus.brake && !w_tilt)
                    w_state_next = ST_RUN;
            ST_RUN:
                if (w_tilt)
                    w_state_next = ST_TILT_FAULT;
                else if (bus.brake)
                    w_state_next = ST_BRAKE;
                else if (!bus.enable)
                    w_state_next = ST_IDLE;
            ST_BRAKE:
                if (w_tilt)
                    w_state_next = ST_TILT_FAULT;
                else if (!bus.brake)
                    w_state_next = ST_IDLE;
            ST_TILT_FAULT:
                // Any non-qualifying cycle leaves w_hold_next at 0.
                if (w_hold_ok) begin
                    if (r_hold == HW'(HOLD_CYCLES - 1))
                        w_state_next = ST_IDLE;
                    else
                        w_hold_next = r_hold + 1'b1;
                end
            default:
                w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tick_next = '0;
        w_duty_next = '0;
        w_gap       = r_target - r_duty;
        w_step      = (w_gap > STEP_W) ? STEP_W : w_gap;
        // Duty only survives while staying in RUN; entering or leaving clears it.
        if (r_state == ST_RUN && w_state_next == ST_RUN) begin
            w_tick_next = (r_tick == TW'(RAMP_DIV - 1)) ? '0 : r_tick + 1'b1;
            if (r_target < r_duty)
                w_duty_next = r_target;
            else if (r_tick == TW'(RAMP_DIV - 1))
                w_duty_next = r_duty + w_step;
            else
                w_duty_next = r_duty;
        end
    end

    always_ff @(posedge c50m or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_duty   <= '0;
            r_tick   <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_target <= bus.mode_sel ? bus.assist_req : bus.throttle;
            r_duty   <= w_duty_next;
            r_tick   <= w_tick_next;
            r_hold   <= w_hold_next;
        end
    end

    motor_pwm_gen #(.WIDTH(WIDTH)) u_pwm (
        .c50m       (c50m),
        .reset      (reset),
        .duty       (r_duty),
        .force_zero (w_force_zero),
        .pwm_out    (bus.pwm_out)
    );

    assign bus.duty  = r_duty;
    assign bus.state = r_state;
endmodule

// File: tb/tb_motor_drive_supervisor.sv
// Directed bench for motor_drive_supervisor: vector table for ramp/mode/priority,
// hand sequences for reset, PWM period and tilt hold (MOTOR_TILT_CUTOFF_EN aware).
module tb_motor_drive_supervisor;
`ifdef MOTOR_TILT_CUTOFF_EN
    localparam int TE = 1;
`else
    localparam int TE = 0;
`endif

    logic c50m = 1'b0;
    logic reset = 1'b1;
    always #5 c50m = ~c50m;

    motor_drive_supervisor_if #(.WIDTH(12)) bus ();

    motor_drive_supervisor #(
        .WIDTH(12), .TILT_LIMIT(512), .RAMP_STEP(16), .RAMP_DIV(4), .HOLD_CYCLES(1000)
    ) dut (
        .c50m  (c50m),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string name;
        int en, ms, brk, assist, thr, roll, pitch;
        int cyc;
        int st, dt, ft;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int passed = 0;

    task automatic add(input string n, input int en, input int ms, input int brk,
                       input int assist, input int thr, input int roll, input int pitch,
                       input int cyc, input int st, input int dt, input int ft);
        vec_t v;
        v.name = n; v.en = en; v.ms = ms; v.brk = brk; v.assist = assist; v.thr = thr;
        v.roll = roll; v.pitch = pitch; v.cyc = cyc; v.st = st; v.dt = dt; v.ft = ft;
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge c50m);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input int en, input int ms, input int brk, input int assist,
                         input int thr, input int roll, input int pitch);
        bus.enable     = en[0];
        bus.mode_sel   = ms[0];
        bus.brake      = brk[0];
        bus.assist_req = 12'(assist);
        bus.throttle   = 12'(thr);
        bus.roll       = 12'(roll);
        bus.pitch      = 12'(pitch);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_duty(input string name, input int target, input int bound);
        int n = 0;
        while (int'(bus.duty) != target && n < bound) begin
            step(1);
            n++;
        end
        chk(name, int'(bus.duty), target);
    endtask

    task automatic find_rise(input string name);
        logic prev;
        int   n = 0;
        int   found = 0;
        while (n < 5000 && found == 0) begin
            prev = bus.pwm_out;
            step(1);
            n++;
            if (!prev && bus.pwm_out) found = 1;
        end
        chk(name, found, 1);
    endtask

    task automatic count_high(input string name, input int exp);
        int hi = 0;
        for (int i = 0; i < 4096; i++) begin
            if (bus.pwm_out) hi++;
            step(1);
        end
        chk(name, hi, exp);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        // name            en ms brk  as   thr  roll pitch cyc st       dt   ft
        add("enter_run",   1, 0, 0,   0,  100,  0,   0,   1,  1,       0,   0);
        add("ramp16",      1, 0, 0,   0,  100,  0,   0,   4,  1,       16,  0);
        add("ramp32",      1, 0, 0,   0,  100,  0,   0,   4,  1,       32,  0);
        add("ramp48",      1, 0, 0,   0,  100,  0,   0,   4,  1,       48,  0);
        add("ramp64",      1, 0, 0,   0,  100,  0,   0,   4,  1,       64,  0);
        add("ramp80",      1, 0, 0,   0,  100,  0,   0,   4,  1,       80,  0);
        add("ramp96",      1, 0, 0,   0,  100,  0,   0,   4,  1,       96,  0);
        add("ramp100",     1, 0, 0,   0,  100,  0,   0,   4,  1,       100, 0);
        add("drop40",      1, 0, 0,   0,  40,   0,   0,   2,  1,       40,  0);
        add("thr50",       1, 0, 0,   300, 50,  0,   0,   2,  1,       50,  0);
        add("mode_assist", 1, 1, 0,   300, 50,  0,   0,   4,  1,       66,  0);
        add("assist_ramp", 1, 1, 0,   300, 50,  0,   0,   4,  1,       82,  0);
        add("mode_thr",    1, 0, 0,   300, 50,  0,   0,   2,  1,       50,  0);
        add("pitch512",    1, 0, 0,   0,  50,   0,   512, 1,  1,       50,  0);
        add("brk_tilt",    1, 0, 1,   0,  50,   0,   513, 1,  TE ? 3 : 2, 0, TE);
        add("release",     1, 0, 0,   0,  50,   0,   0,   1,  TE ? 3 : 0, 0, TE);

        reset = 1'b1;
        step(2);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_duty", int'(bus.duty), 0);
        chk("rst_pwm", int'(bus.pwm_out), 0);
        chk("rst_fault", int'(bus.fault_tilt), 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].ms, vecs[i].brk, vecs[i].assist,
                  vecs[i].thr, vecs[i].roll, vecs[i].pitch);
            step(vecs[i].cyc);
            chk({vecs[i].name, "_state"}, int'(bus.state), vecs[i].st);
            chk({vecs[i].name, "_duty"}, int'(bus.duty), vecs[i].dt);
            chk({vecs[i].name, "_fault"}, int'(bus.fault_tilt), vecs[i].ft);
        end

        // Asynchronous reset in the middle of a ramp.
        do_reset();
        drive(1, 0, 0, 0, 100, 0, 0);
        wait_duty("reach64", 64, 100);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_duty", int'(bus.duty), 0);
        chk("mid_rst_state", int'(bus.state), 0);
        chk("mid_rst_pwm", int'(bus.pwm_out), 0);
        chk("mid_rst_fault", int'(bus.fault_tilt), 0);
        step(2);
        reset = 1'b0;
        chk("post_rst_state", int'(bus.state), 0);
        step(1);
        chk("post_rst_run", int'(bus.state), 1);

        // PWM duty cycle and wrap-deferred compare update.
        do_reset();
        drive(1, 0, 0, 0, 2048, 0, 0);
        wait_duty("reach2048", 2048, 1000);
        step(4200);
        find_rise("pwm_rise1");
        count_high("pwm_hi2048", 2048);
        step(500);
        drive(1, 0, 0, 0, 40, 0, 0);
        step(100);
        chk("duty40", int'(bus.duty), 40);
        chk("pwm_deferred", int'(bus.pwm_out), 1);
        find_rise("pwm_rise2");
        count_high("pwm_hi40", 40);

`ifdef MOTOR_TILT_CUTOFF_EN
        do_reset();
        drive(1, 0, 0, 0, 800, 0, 0);
        wait_duty("reach800", 800, 600);
        drive(1, 0, 0, 0, 800, -600, 0);
        step(2);
        chk("tilt_state", int'(bus.state), 3);
        chk("tilt_fault", int'(bus.fault_tilt), 1);
        chk("tilt_duty", int'(bus.duty), 0);
        chk("tilt_pwm", int'(bus.pwm_out), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step(900);
        chk("hold_900", int'(bus.state), 3);
        step(200);
        chk("hold_exit", int'(bus.state), 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        step(2);
        chk("rerun", int'(bus.state), 1);
        drive(1, 0, 0, 0, 0, -2048, 0);
        step(1);
        chk("tilt_sat", int'(bus.state), 3);
        drive(0, 0, 0, 0, 0, 0, 0);
        step(500);
        bus.throttle = 12'd5;
        step(1);
        bus.throttle = 12'd0;
        step(900);
        chk("blip_restart", int'(bus.state), 3);
        step(200);
        chk("blip_exit", int'(bus.state), 0);
`else
        do_reset();
        drive(1, 0, 0, 0, 100, 0, 0);
        step(3);
        drive(1, 0, 0, 0, 100, -2048, 0);
        step(10);
        chk("notilt_state", int'(bus.state), 1);
        chk("notilt_fault", int'(bus.fault_tilt), 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
